// File: rtl/scarv_cop_mpalu.sv
// rtl/scarv_cop_mpalu.sv - multi-precision ALU with iterative radix-2^MUL_R multiplier
module scarv_cop_mpalu #(
  parameter int XLEN  = 32,
  parameter int MUL_R = 8
) (
  input  logic                      g_clk,
  input  logic                      g_resetn,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic [XLEN-1:0]           in_rs1,
  input  logic [XLEN-1:0]           in_rs2,
  input  logic [XLEN-1:0]           in_rs3,
  input  logic [$clog2(2*XLEN)-1:0] in_shamt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_hi,
  output logic [XLEN-1:0]           out_lo,
  output logic                      busy
);

  localparam int DW   = 2 * XLEN;
  localparam int NMUL = XLEN / MUL_R;
  localparam int CW   = (NMUL > 1) ? $clog2(NMUL) : 1;

  localparam logic [2:0] OP_ADD3 = 3'd0;
  localparam logic [2:0] OP_SUB3 = 3'd1;
  localparam logic [2:0] OP_ACC1 = 3'd2;
  localparam logic [2:0] OP_MAC  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_SLL  = 3'd5;
  localparam logic [2:0] OP_SRL  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [DW-1:0]   acc;
  logic [DW-1:0]   mul_a;     // rs1 pre-shifted to the current digit position
  logic [XLEN-1:0] mul_b;     // rs2 shifted so the current digit sits at bit 0
  logic [CW-1:0]   cnt;

  logic [DW-1:0]   ext1, ext2, ext3, cat12;
  logic [DW-1:0]   alu_res;
  logic [DW-1:0]   mul_pp;
  logic [DW-1:0]   acc_nxt;
  logic            is_mul;
  logic            mul_last;

  assign ext1  = {{XLEN{1'b0}}, in_rs1};
  assign ext2  = {{XLEN{1'b0}}, in_rs2};
  assign ext3  = {{XLEN{1'b0}}, in_rs3};
  assign cat12 = {in_rs1, in_rs2};

  assign is_mul   = (in_op == OP_MAC) || (in_op == OP_MUL);
  assign mul_last = (cnt == CW'(NMUL - 1));

  // Shifting mul_a/mul_b each step turns rs2[cnt*R +: R] << cnt*R into a fixed-position product
  assign mul_pp  = mul_a * {{(DW - MUL_R){1'b0}}, mul_b[MUL_R-1:0]};
  assign acc_nxt = acc + mul_pp;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // Single-cycle result for every non-multiply op, modulo 2^(2*XLEN)
  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD3: alu_res = ext1 + ext2 + ext3;
      OP_SUB3: alu_res = ext1 - ext2 - ext3;
      OP_ACC1: alu_res = {in_rs2, in_rs3} + ext1;
      OP_SLL:  alu_res = cat12 << in_shamt;
      OP_SRL:  alu_res = cat12 >> in_shamt;
      default: alu_res = '0;
    endcase
  end

  // Control FSM and datapath registers; reset beats flush, flush beats everything else
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state  <= S_IDLE;
      acc    <= '0;
      cnt    <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      out_hi <= '0;
      out_lo <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (is_mul) begin
              state <= S_MUL;
              acc   <= (in_op == OP_MAC) ? ext3 : '0;
              mul_a <= ext1;
              mul_b <= in_rs2;
              cnt   <= '0;
            end else begin
              state            <= S_DONE;
              {out_hi, out_lo} <= alu_res;
            end
          end
        end
        S_MUL: begin
          acc   <= acc_nxt;
          mul_a <= mul_a << MUL_R;
          mul_b <= mul_b >> MUL_R;
          cnt   <= cnt + CW'(1);
          if (mul_last) begin
            state            <= S_DONE;
            {out_hi, out_lo} <= acc_nxt;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scarv_cop_mpalu.sv
// tb/tb_scarv_cop_mpalu.sv - randomized and directed bench for scarv_cop_mpalu
module tb_scarv_cop_mpalu;

  localparam int XLEN  = 32;
  localparam int MUL_R = 8;
  localparam int NMUL  = XLEN / MUL_R;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  in_op = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, in_rs3 = '0;
  logic [5:0]  in_shamt = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_hi, out_lo;

  logic        c64_valid = 1'b0, c64_rdy, c64_ov, c64_busy;
  logic [63:0] c64_hi, c64_lo;
  logic        c4_valid = 1'b0, c4_rdy, c4_ov, c4_busy;
  logic [31:0] c4_hi, c4_lo;

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  scarv_cop_mpalu #(.XLEN(XLEN), .MUL_R(MUL_R)) u_dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_shamt(in_shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hi(out_hi), .out_lo(out_lo), .busy(busy)
  );

  scarv_cop_mpalu #(.XLEN(64), .MUL_R(16)) u_c64 (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(1'b0),
    .in_valid(c64_valid), .in_ready(c64_rdy), .in_op(3'd3),
    .in_rs1({64{1'b1}}), .in_rs2({64{1'b1}}), .in_rs3({64{1'b1}}), .in_shamt(7'd0),
    .out_valid(c64_ov), .out_ready(1'b1),
    .out_hi(c64_hi), .out_lo(c64_lo), .busy(c64_busy)
  );

  scarv_cop_mpalu #(.XLEN(32), .MUL_R(4)) u_c4 (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(1'b0),
    .in_valid(c4_valid), .in_ready(c4_rdy), .in_op(3'd3),
    .in_rs1(32'hFFFF_FFFF), .in_rs2(32'hFFFF_FFFF), .in_rs3(32'hFFFF_FFFF), .in_shamt(6'd0),
    .out_valid(c4_ov), .out_ready(1'b1),
    .out_hi(c4_hi), .out_lo(c4_lo), .busy(c4_busy)
  );

  // Reference: the arithmetic meaning of each op on 64-bit values
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, b, c,
                                          input logic [5:0] sh);
    logic [63:0] wa, wb, wc, cat;
    wa = {32'd0, a}; wb = {32'd0, b}; wc = {32'd0, c}; cat = {a, b};
    case (op)
      3'd0:    return wa + wb + wc;
      3'd1:    return wa - wb - wc;
      3'd2:    return {b, c} + wa;
      3'd3:    return wa * wb + wc;
      3'd4:    return wa * wb;
      3'd5:    return cat << sh;
      3'd6:    return cat >> sh;
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op);
    return (op == 3'd3 || op == 3'd4) ? NMUL + 1 : 1;
  endfunction

  // Drive one op, return its result and the cycle (relative to accept) where out_valid first rose
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, c, input logic [5:0] sh,
                        output logic [31:0] hi, lo, output int lat);
    int n;
    @(negedge g_clk);
    in_op = op; in_rs1 = a; in_rs2 = b; in_rs3 = c; in_shamt = sh; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge g_clk); n++; end
    @(posedge g_clk);
    @(negedge g_clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin @(negedge g_clk); lat++; end
    if (!out_valid) lat = -1;
    hi = out_hi; lo = out_lo;
    out_ready = 1'b1;
    @(negedge g_clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    repeat (3) @(negedge g_clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_hi !== '0 || out_lo !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b ov=%b busy=%b hi=%h lo=%h required rdy=1 ov=0 busy=0 hi=0 lo=0",
               in_ready, out_valid, busy, out_hi, out_lo);
    end
    g_resetn = 1'b1;
    @(negedge g_clk);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, c;
    logic [5:0]  sh;
    logic [31:0] hi, lo;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    logic [31:0] hi, lo;
    int lat;
    v.push_back('{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd0,  32'h00000002, 32'hFFFFFFFD, 1});
    v.push_back('{3'd1, 32'h0,        32'h1,        32'h0,        6'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 1});
    v.push_back('{3'd2, 32'h1,        32'h0,        32'hFFFFFFFF, 6'd0,  32'h00000001, 32'h00000000, 1});
    v.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd0,  32'hFFFFFFFF, 32'h00000000, 5});
    v.push_back('{3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 6'd0,  32'hFFFFFFFE, 32'h00000001, 5});
    v.push_back('{3'd5, 32'h0,        32'h80000000, 32'h0,        6'd1,  32'h00000001, 32'h00000000, 1});
    v.push_back('{3'd6, 32'h80000000, 32'h0,        32'h0,        6'd63, 32'h00000000, 32'h00000001, 1});
    v.push_back('{3'd5, 32'h12345678, 32'h9ABCDEF0, 32'h0,        6'd0,  32'h12345678, 32'h9ABCDEF0, 1});
    v.push_back('{3'd6, 32'h12345678, 32'h9ABCDEF0, 32'h0,        6'd0,  32'h12345678, 32'h9ABCDEF0, 1});
    v.push_back('{3'd5, 32'h0,        32'h1,        32'h0,        6'd63, 32'h80000000, 32'h00000000, 1});
    v.push_back('{3'd7, 32'hDEADBEEF, 32'hCAFEF00D, 32'h1,        6'd5,  32'h00000000, 32'h00000000, 1});
    v.push_back('{3'd1, 32'h5,        32'h2,        32'h3,        6'd0,  32'h00000000, 32'h00000000, 1});
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].c, v[i].sh, hi, lo, lat);
      checks++;
      if (hi !== v[i].hi || lo !== v[i].lo) begin
        errors++;
        $display("FAIL directed_result[%0d] op=%0d: got %h_%h required %h_%h", i, v[i].op, hi, lo, v[i].hi, v[i].lo);
      end
      checks++;
      if (lat !== v[i].lat) begin
        errors++;
        $display("FAIL directed_latency[%0d] op=%0d: got %0d required %0d", i, v[i].op, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, c, hi, lo;
    logic [5:0]  sh;
    logic [63:0] exp;
    int lat;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom; c = $urandom;
      if (i % 5 == 0) a = 32'hFFFFFFFF;
      sh = 6'($urandom_range(0, 63));
      exp = ref_res(op, a, b, c, sh);
      run_op(op, a, b, c, sh, hi, lo, lat);
      checks++;
      if ({hi, lo} !== exp) begin
        errors++;
        $display("FAIL random_result op=%0d a=%h b=%h c=%h sh=%0d: got %h_%h required %h",
                 op, a, b, c, sh, hi, lo, exp);
      end
      checks++;
      if (lat !== ref_lat(op)) begin
        errors++;
        $display("FAIL random_latency op=%0d: got %0d required %0d", op, lat, ref_lat(op));
      end
    end
  endtask

  task automatic test_configs();
    int lat64, lat4;
    logic [63:0] h64, l64;
    logic [31:0] h4, l4;
    lat64 = 0; lat4 = 0; h64 = '0; l64 = '0; h4 = '0; l4 = '0;
    @(negedge g_clk);
    c64_valid = 1'b1; c4_valid = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    c64_valid = 1'b0; c4_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (c64_ov && lat64 == 0) begin lat64 = k; h64 = c64_hi; l64 = c64_lo; end
      if (c4_ov && lat4 == 0) begin lat4 = k; h4 = c4_hi; l4 = c4_lo; end
      @(negedge g_clk);
    end
    checks++;
    if (lat64 !== 5 || h64 !== {64{1'b1}} || l64 !== 64'd0) begin
      errors++;
      $display("FAIL mac_x64_r16: got lat=%0d %h_%h required lat=5 %h_%h", lat64, h64, l64, {64{1'b1}}, 64'd0);
    end
    checks++;
    if (lat4 !== 9 || h4 !== 32'hFFFFFFFF || l4 !== 32'd0) begin
      errors++;
      $display("FAIL mac_x32_r4: got lat=%0d %h_%h required lat=9 ffffffff_00000000", lat4, h4, l4);
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge g_clk);
    in_op = 3'd0; in_rs1 = 32'd1; in_rs2 = 32'd2; in_rs3 = 32'd3; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge g_clk); n++; end
    @(posedge g_clk);
    @(negedge g_clk);
    in_op = 3'd1; in_rs1 = 32'd10; in_rs2 = 32'd3; in_rs3 = 32'd2;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_hi !== 32'd0 || out_lo !== 32'd6) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got ov=%b rdy=%b %h_%h required ov=1 rdy=0 00000000_00000006",
                 k, out_valid, in_ready, out_hi, out_lo);
      end
      if (k < 3) @(negedge g_clk);
    end
    out_ready = 1'b1;
    @(negedge g_clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: got rdy=%b ov=%b required rdy=1 ov=0", in_ready, out_valid);
    end
    @(posedge g_clk);
    @(negedge g_clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_hi !== 32'd0 || out_lo !== 32'd5) begin
      errors++;
      $display("FAIL backpressure_queued: got ov=%b %h_%h required ov=1 00000000_00000005", out_valid, out_hi, out_lo);
    end
    out_ready = 1'b1;
    @(negedge g_clk);
    out_ready = 1'b0;
  endtask

  task automatic start_mul(input logic [31:0] a, b);
    int n;
    @(negedge g_clk);
    in_op = 3'd4; in_rs1 = a; in_rs2 = b; in_rs3 = 32'd0; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge g_clk); n++; end
    @(posedge g_clk);
    @(negedge g_clk);
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] a, b, c, hi, lo;
    int lat, seen;
    start_mul(32'h7, 32'h9);
    seen = out_valid;
    @(negedge g_clk);
    seen |= out_valid;
    flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_mul: got busy=%b rdy=%b ov=%b required busy=0 rdy=1 ov=0", busy, in_ready, out_valid);
    end
    for (int k = 0; k < 6; k++) begin @(negedge g_clk); seen |= out_valid; end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_no_output: got out_valid seen=%0d required 0", seen);
    end
    a = $urandom; b = $urandom; c = $urandom;
    run_op(3'd0, a, b, c, 6'd0, hi, lo, lat);
    checks++;
    if ({hi, lo} !== ref_res(3'd0, a, b, c, 6'd0) || lat !== 1) begin
      errors++;
      $display("FAIL flush_then_add3: got %h_%h lat=%0d required %h lat=1", hi, lo, lat, ref_res(3'd0, a, b, c, 6'd0));
    end
    @(negedge g_clk);
    in_op = 3'd0; in_rs1 = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(negedge g_clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_with_accept: got busy=%b ov=%b required busy=0 ov=0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] hi, lo;
    int lat;
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd0, hi, lo, lat);
    start_mul(32'h1234, 32'h5678);
    @(negedge g_clk);
    g_resetn = 1'b0;
    @(negedge g_clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_hi !== '0 || out_lo !== '0) begin
      errors++;
      $display("FAIL reset_mid_mul: got rdy=%b ov=%b busy=%b hi=%h lo=%h required rdy=1 ov=0 busy=0 hi=0 lo=0",
               in_ready, out_valid, busy, out_hi, out_lo);
    end
    g_resetn = 1'b1;
    @(negedge g_clk);
  endtask

  initial begin
    test_reset();
    test_configs();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
